// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic feeder: default geometry, FSM states,
// and the skew-line drain depth helper.
package systolic_pkg;

    localparam int DBITS_DEF = 8;
    localparam int ROWS_DEF  = 2;
    localparam int COLS_DEF  = 2;
    localparam int KMAX_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } feeder_state_e;

    // Extra cycles the deepest lane needs beyond the shallowest one.
    function automatic int drain_depth(input int rows, input int cols);
        return ((rows > cols) ? rows : cols) - 1;
    endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// One skewed operand lane: DEPTH register stages of data plus valid.
// SYSTOLIC_FEEDER_ZERO_GATE_EN forces data to zero in invalid slots.
module systolic_skew_line #(
    parameter int DBITS = 8,
    parameter int DEPTH = 1
) (
    input  logic             i_CLK,
    input  logic             i_RSTN,
    input  logic             i_VALID,
    input  logic [DBITS-1:0] i_DATA,
    output logic             o_VALID,
    output logic [DBITS-1:0] o_DATA
);

    logic [DEPTH-1:0] r_vld;
    logic [DBITS-1:0] r_dat [DEPTH];
    logic [DBITS-1:0] w_head;

`ifdef SYSTOLIC_FEEDER_ZERO_GATE_EN
    assign w_head = i_VALID ? i_DATA : {DBITS{1'b0}};
`else
    assign w_head = i_DATA;
`endif

    // Unconditional shift; idle cycles inject bubbles so every lane stays aligned.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_vld <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_dat[i] <= {DBITS{1'b0}};
            end
        end else begin
            r_vld[0] <= i_VALID;
            r_dat[0] <= w_head;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign o_VALID = r_vld[DEPTH-1];
    assign o_DATA  = r_dat[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews A/B k-slices into a diagonal wavefront and frames tiles with a done pulse.
// Optional zero gating of invalid slots: SYSTOLIC_FEEDER_ZERO_GATE_EN.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int DBITS = DBITS_DEF,
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int KMAX  = KMAX_DEF
) (
    input  logic                        i_CLK,
    input  logic                        i_RSTN,
    input  logic                        i_VALID,
    output logic                        o_READY,
    input  logic                        i_LAST,
    input  logic [ROWS*DBITS-1:0]       i_A,
    input  logic [COLS*DBITS-1:0]       i_B,
    output logic [ROWS*DBITS-1:0]       o_A,
    output logic [ROWS-1:0]             o_A_VALID,
    output logic [COLS*DBITS-1:0]       o_B,
    output logic [COLS-1:0]             o_B_VALID,
    output logic                        o_BUSY,
    output logic                        o_TILE_DONE,
    output logic [$clog2(KMAX+1)-1:0]   o_BEAT_CNT,
    output logic                        o_OVF
);

    localparam int D   = drain_depth(ROWS, COLS);
    localparam int DCW = (D < 1) ? 1 : $clog2(D + 1);
    localparam int BW  = $clog2(KMAX + 1);

    feeder_state_e  r_state;
    logic           r_ready;
    logic           r_busy;
    logic           r_done;
    logic [DCW-1:0] r_dcnt;
    logic [BW-1:0]  r_beat_cnt;
    logic           r_ovf;
    logic           w_accept;

    assign w_accept = i_VALID & r_ready;

    // Tile FSM; r_dcnt counts DRAIN cycles still to go after the current one.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dcnt  <= {DCW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE, ST_STREAM: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        if (i_LAST) begin
                            r_state <= ST_DRAIN;
                            r_ready <= 1'b0;
                            r_dcnt  <= DCW'(D);
                            r_done  <= (D == 0);
                        end else begin
                            r_state <= ST_STREAM;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_dcnt == {DCW{1'b0}}) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt - DCW'(1);
                        r_done <= (r_dcnt == DCW'(1));
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_dcnt  <= {DCW{1'b0}};
                end
            endcase
        end
    end

    // Beat counter restarts on a tile's first accept and saturates at KMAX.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_beat_cnt <= {BW{1'b0}};
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            if (r_state == ST_IDLE) begin
                r_beat_cnt <= BW'(1);
            end else if (r_beat_cnt == BW'(KMAX)) begin
                r_ovf <= 1'b1;
            end else begin
                r_beat_cnt <= r_beat_cnt + BW'(1);
            end
        end else begin
            r_beat_cnt <= r_beat_cnt;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
        systolic_skew_line #(.DBITS(DBITS), .DEPTH(r + 1)) u_line (
            .i_CLK   (i_CLK),
            .i_RSTN  (i_RSTN),
            .i_VALID (w_accept),
            .i_DATA  (i_A[r*DBITS +: DBITS]),
            .o_VALID (o_A_VALID[r]),
            .o_DATA  (o_A[r*DBITS +: DBITS])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_lane
        systolic_skew_line #(.DBITS(DBITS), .DEPTH(c + 1)) u_line (
            .i_CLK   (i_CLK),
            .i_RSTN  (i_RSTN),
            .i_VALID (w_accept),
            .i_DATA  (i_B[c*DBITS +: DBITS]),
            .o_VALID (o_B_VALID[c]),
            .o_DATA  (o_B[c*DBITS +: DBITS])
        );
    end

    assign o_READY     = r_ready;
    assign o_BUSY      = r_busy;
    assign o_TILE_DONE = r_done;
    assign o_BEAT_CNT  = r_beat_cnt;
    assign o_OVF       = r_ovf;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder (DBITS=8, ROWS=COLS=2, KMAX=4):
// a cycle-indexed reference model predicts lane arrivals and control outputs.
module tb_systolic_skew_feeder;

    localparam int DB = 8;
    localparam int NR = 2;
    localparam int NC = 2;
    localparam int KM = 4;
    localparam int DD = 1;
    localparam int NL = NR + NC;

    logic                 clk = 1'b0;
    logic                 i_RSTN = 1'b0;
    logic                 i_VALID = 1'b0;
    logic                 i_LAST = 1'b0;
    logic [NR*DB-1:0]     i_A = '0;
    logic [NC*DB-1:0]     i_B = '0;
    logic                 o_READY, o_BUSY, o_TILE_DONE, o_OVF;
    logic [NR*DB-1:0]     o_A;
    logic [NC*DB-1:0]     o_B;
    logic [NR-1:0]        o_A_VALID;
    logic [NC-1:0]        o_B_VALID;
    logic [2:0]           o_BEAT_CNT;

    systolic_skew_feeder #(.DBITS(DB), .ROWS(NR), .COLS(NC), .KMAX(KM)) dut (
        .i_CLK(clk), .i_RSTN(i_RSTN), .i_VALID(i_VALID), .o_READY(o_READY),
        .i_LAST(i_LAST), .i_A(i_A), .i_B(i_B), .o_A(o_A), .o_A_VALID(o_A_VALID),
        .o_B(o_B), .o_B_VALID(o_B_VALID), .o_BUSY(o_BUSY), .o_TILE_DONE(o_TILE_DONE),
        .o_BEAT_CNT(o_BEAT_CNT), .o_OVF(o_OVF)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; int cyc; } beat_t;
    typedef struct { bit ready; bit busy; bit done; int cnt; bit ovf; } ctl_t;

    beat_t lq [NL][$];
    ctl_t  cq [$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_err = 0;

    int    m_ready_from = 0;
    int    m_done_cyc = -1;
    bit    m_in_tile = 0;
    int    m_cnt = 0;
    bit    m_ovf = 0;
    bit    m_acc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: a beat accepted at edge e shows on lane k at cycle e+1+k.
    initial forever begin
        int   e;
        ctl_t c;
        @(posedge clk);
        e = cyc;
        if (!i_RSTN) begin
            for (int l = 0; l < NL; l++) lq[l].delete();
            m_ready_from = 0; m_done_cyc = -1; m_in_tile = 0;
            m_cnt = 0; m_ovf = 0; m_acc = 0;
        end else begin
            m_acc = i_VALID && (e >= m_ready_from);
            if (m_acc) begin
                if (!m_in_tile) m_cnt = 1;
                else if (m_cnt == KM) m_ovf = 1;
                else m_cnt = m_cnt + 1;
                for (int r = 0; r < NR; r++) lq[r].push_back('{i_A[r*DB +: DB], e + 1 + r});
                for (int k = 0; k < NC; k++) lq[NR+k].push_back('{i_B[k*DB +: DB], e + 1 + k});
                if (i_LAST) begin
                    m_in_tile = 0;
                    m_ready_from = e + 2 + DD;
                    m_done_cyc = e + 1 + DD;
                end else begin
                    m_in_tile = 1;
                end
            end
        end
        c.ready = (e + 1 >= m_ready_from);
        c.busy  = m_in_tile || (e + 1 < m_ready_from);
        c.done  = (m_done_cyc == e + 1);
        c.cnt   = m_cnt;
        c.ovf   = m_ovf;
        cq.push_back(c);
        cyc = e + 1;
    end

    // Monitor: compares control every cycle and pops lane beats as valids appear.
    initial forever begin
        ctl_t c;
        bit   act_v, exp_v;
        logic [7:0] act_d;
        @(negedge clk);
        if (cq.size() > 0) begin
            c = cq.pop_front();
            chk("ready", int'(o_READY), int'(c.ready));
            chk("busy", int'(o_BUSY), int'(c.busy));
            chk("tile_done", int'(o_TILE_DONE), int'(c.done));
            chk("beat_cnt", int'(o_BEAT_CNT), c.cnt);
            chk("ovf", int'(o_OVF), int'(c.ovf));
        end
        for (int l = 0; l < NL; l++) begin
            act_v = (l < NR) ? o_A_VALID[l] : o_B_VALID[l-NR];
            act_d = (l < NR) ? o_A[l*DB +: DB] : o_B[(l-NR)*DB +: DB];
            exp_v = (lq[l].size() > 0) && (lq[l][0].cyc == cyc);
            chk($sformatf("lane%0d_valid", l), int'(act_v), int'(exp_v));
            if (exp_v) begin
                if (act_v) chk($sformatf("lane%0d_data", l), int'(act_d), int'(lq[l][0].d));
                void'(lq[l].pop_front());
            end
`ifdef SYSTOLIC_FEEDER_ZERO_GATE_EN
            else if (!act_v) begin
                chk($sformatf("lane%0d_zero", l), int'(act_d), 0);
            end
`endif
        end
    end

    task automatic drive(input bit v, input logic [15:0] a, input logic [15:0] b, input bit last);
        int waited;
        waited = 0;
        #1;
        i_RSTN = 1'b1; i_VALID = v; i_A = a; i_B = b; i_LAST = last;
        @(negedge clk);
        while (v && !m_acc) begin
            waited++;
            if (waited > 20) begin
                chk("accept_timeout", 0, 1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic reset_pulse();
        #1;
        i_RSTN = 1'b0; i_VALID = 1'b0; i_LAST = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        reset_pulse();
        idle(2);
        // single LAST beat
        drive(1'b1, 16'h0201, 16'h0403, 1'b1);
        idle(4);
        // 4-beat continuous tile
        for (int k = 0; k < 4; k++)
            drive(1'b1, {8'h10 + 8'(k), 8'(k)}, 16'($urandom), (k == 3));
        idle(4);
        // input gap, with a stray LAST on the idle slot
        drive(1'b1, 16'hA1A0, 16'hB1B0, 1'b0);
        drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        drive(1'b1, 16'hA3A2, 16'hB3B2, 1'b1);
        idle(4);
        // back-to-back tiles, second held off through DRAIN
        drive(1'b1, 16'h1111, 16'h2222, 1'b1);
        drive(1'b1, 16'h3333, 16'h4444, 1'b0);
        drive(1'b1, 16'h5555, 16'h6666, 1'b1);
        idle(4);
        // overflow: 5 beats with KMAX=4
        for (int k = 0; k < 5; k++)
            drive(1'b1, 16'($urandom), 16'($urandom), (k == 4));
        idle(4);
        // reset mid-stream
        for (int k = 0; k < 3; k++)
            drive(1'b1, 16'($urandom), 16'($urandom), 1'b0);
        reset_pulse();
        idle(5);
        // randomized tiles with random gaps
        for (int t = 0; t < 30; t++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 2) == 0)
                    drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
                drive(1'b1, 16'($urandom), 16'($urandom), (k == len - 1));
            end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        idle(6);
        chk("lanes_drained", lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
